// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [7:0]  BE_DWORD         = 8'hFF;
  localparam logic [63:0] DWORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: byte enables and store-data replication outward, load lane extraction inward.
// Purely combinational; no latency, no backpressure.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic        byte_sel,
  input  logic [2:0]  byte_off,
  input  logic [63:0] wdata,
  input  logic [63:0] load_buf,
  output logic [7:0]  be,
  output logic [63:0] wdata_aligned,
  output logic [63:0] load_data
);

  always_comb begin
    if (byte_sel) begin
      be            = 8'b1 << byte_off;
      // Replicating the byte lets memory pick it off whichever lane be selects.
      wdata_aligned = {8{wdata[7:0]}};
      load_data     = {56'd0, load_buf[{byte_off, 3'b000} +: 8]};
    end else begin
      be            = BE_DWORD;
      wdata_aligned = wdata;
      load_data     = load_buf;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage LDUR/LDURB/STUR/STURB req/ack controller; timeout abort under MEM_TIMEOUT_EN.
// Latency: non-mem ops 0 cycles; mem ops 2+N cycles (N = REQ cycles until mem_ack).
// Backpressure: stall held from the issue cycle through REQ; released in DONE.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        MemRead_ex,
    input  logic        MemWrite_ex,
    input  logic        ByteSel_ex,
    input  logic [63:0] alu_result_ex,
    input  logic [63:0] wdata_ex,
    input  logic        RegWrite_ex,
    input  logic        Reg3Loc_ex,
    input  logic [31:0] instr_ex,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
`ifdef MEM_TIMEOUT_EN
    output logic        mem_fault,
`endif
    output logic        stall,
    output logic [63:0] data_to_reg_mem,
    output logic        RegWrite_reg_mem,
    output logic        Reg3Loc_mem,
    output logic [31:0] instr_reg_mem
);

    mem_state_t  state, state_nxt;
    logic [63:0] load_buf;
    logic [63:0] load_data;
    logic        memop;
    logic        timeout_hit;
    logic        fault_q;

    assign memop         = ex_valid & (MemRead_ex | MemWrite_ex);
    assign mem_we        = MemWrite_ex;
    assign mem_addr      = alu_result_ex & DWORD_ALIGN_MASK;
    assign Reg3Loc_mem   = Reg3Loc_ex;
    assign instr_reg_mem = instr_ex;

    mem_lane_align u_lane_align (
        .byte_sel      (ByteSel_ex),
        .byte_off      (alu_result_ex[2:0]),
        .wdata         (wdata_ex),
        .load_buf      (load_buf),
        .be            (mem_be),
        .wdata_aligned (mem_wdata),
        .load_data     (load_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;

    assign timeout_hit = (state == REQ) & ~mem_ack & (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            to_cnt  <= (state == REQ && state_nxt == REQ) ? to_cnt + 8'd1 : 8'd0;
            fault_q <= timeout_hit;
        end
    end

    assign mem_fault = fault_q;
`else
    assign timeout_hit = 1'b0;
    assign fault_q     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        load_buf <= 64'd0;
        else if (state == REQ && mem_ack) load_buf <= mem_rdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (memop) state_nxt = REQ;
            REQ:     if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req          = 1'b0;
        stall            = 1'b0;
        data_to_reg_mem  = alu_result_ex;
        RegWrite_reg_mem = RegWrite_ex & ex_valid;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall            = 1'b1;
                    RegWrite_reg_mem = 1'b0;
                end
            end
            REQ: begin
                mem_req          = 1'b1;
                stall            = 1'b1;
                RegWrite_reg_mem = 1'b0;
            end
            DONE: begin
                if (fault_q) begin
                    data_to_reg_mem  = 64'd0;
                    RegWrite_reg_mem = 1'b0;
                end else begin
                    data_to_reg_mem  = MemRead_ex ? load_data : 64'd0;
                    RegWrite_reg_mem = RegWrite_ex;
                end
            end
            default: ;
        endcase
        if (reset) RegWrite_reg_mem = 1'b0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed check of mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRead_ex, MemWrite_ex, ByteSel_ex;
    logic [63:0] alu_result_ex, wdata_ex;
    logic        RegWrite_ex, Reg3Loc_ex;
    logic [31:0] instr_ex;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic        stall, RegWrite_reg_mem, Reg3Loc_mem;
    logic [63:0] data_to_reg_mem;
    logic [31:0] instr_reg_mem;
`ifdef MEM_TIMEOUT_EN
    logic        mem_fault;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .MemRead_ex       (MemRead_ex),
        .MemWrite_ex      (MemWrite_ex),
        .ByteSel_ex       (ByteSel_ex),
        .alu_result_ex    (alu_result_ex),
        .wdata_ex         (wdata_ex),
        .RegWrite_ex      (RegWrite_ex),
        .Reg3Loc_ex       (Reg3Loc_ex),
        .instr_ex         (instr_ex),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_be           (mem_be),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
`ifdef MEM_TIMEOUT_EN
        .mem_fault        (mem_fault),
`endif
        .stall            (stall),
        .data_to_reg_mem  (data_to_reg_mem),
        .RegWrite_reg_mem (RegWrite_reg_mem),
        .Reg3Loc_mem      (Reg3Loc_mem),
        .instr_reg_mem    (instr_reg_mem)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_be(input bit bsel, input logic [63:0] a);
        return bsel ? 8'(1 << a[2:0]) : 8'hFF;
    endfunction

    function automatic logic [63:0] exp_wdata(input bit bsel, input logic [63:0] wd);
        return bsel ? 64'h0101_0101_0101_0101 * {56'd0, wd[7:0]} : wd;
    endfunction

    function automatic logic [63:0] exp_load(input bit bsel, input logic [63:0] a, input logic [63:0] rd);
        return bsel ? ((rd >> (8 * a[2:0])) & 64'hFF) : rd;
    endfunction

    task automatic do_op(input bit rd, input bit wr, input bit bsel, input bit rw,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rdat, input int ack_lat);
        logic [31:0] ins;
        bit          r3;
        ins = $urandom;
        r3  = 1'($urandom_range(0, 1));
        ex_valid = 1'b1; MemRead_ex = rd; MemWrite_ex = wr; ByteSel_ex = bsel;
        alu_result_ex = a; wdata_ex = wd; RegWrite_ex = rw; Reg3Loc_ex = r3; instr_ex = ins;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("instr_pass", {32'd0, instr_reg_mem}, {32'd0, ins});
        chk("r3loc_pass", {63'd0, Reg3Loc_mem}, {63'd0, r3});
        chk("issue_req", {63'd0, mem_req}, 64'd0);
        if (!(rd || wr)) begin
            chk("alu_stall", {63'd0, stall}, 64'd0);
            chk("alu_data", data_to_reg_mem, a);
            chk("alu_rw", {63'd0, RegWrite_reg_mem}, {63'd0, rw});
        end else begin
            chk("issue_stall", {63'd0, stall}, 64'd1);
            chk("issue_rw", {63'd0, RegWrite_reg_mem}, 64'd0);
            for (int c = 1; c <= ack_lat; c++) begin
                @(posedge clk); #1;
                mem_ack   = (c == ack_lat);
                mem_rdata = (c == ack_lat) ? rdat : {$urandom, $urandom};
                @(negedge clk);
                chk("req_req", {63'd0, mem_req}, 64'd1);
                chk("req_stall", {63'd0, stall}, 64'd1);
                chk("req_rw", {63'd0, RegWrite_reg_mem}, 64'd0);
                chk("req_we", {63'd0, mem_we}, {63'd0, wr});
                chk("req_addr", mem_addr, a & ~64'h7);
                chk("req_be", {56'd0, mem_be}, {56'd0, exp_be(bsel, a)});
                if (wr) chk("req_wdata", mem_wdata, exp_wdata(bsel, wd));
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("done_req", {63'd0, mem_req}, 64'd0);
            chk("done_stall", {63'd0, stall}, 64'd0);
            chk("done_rw", {63'd0, RegWrite_reg_mem}, {63'd0, rw});
            chk("done_data", data_to_reg_mem, rd ? exp_load(bsel, a, rdat) : 64'd0);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; MemRead_ex = 1'b0; MemWrite_ex = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b1; MemRead_ex = 1'b0; MemWrite_ex = 1'b0; ByteSel_ex = 1'b0;
        alu_result_ex = 64'h55; wdata_ex = 64'd0; RegWrite_ex = 1'b1; Reg3Loc_ex = 1'b0;
        instr_ex = 32'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
        #2;
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_rw", {63'd0, RegWrite_reg_mem}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_fault", {63'd0, mem_fault}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_op(0, 0, 0, 1, 64'h1234, 64'd0, 64'd0, 1);
        do_op(1, 0, 0, 1, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 3);
        do_op(1, 0, 1, 1, 64'h43, 64'd0, 64'h8877665544332211, 2);
        do_op(0, 1, 1, 0, 64'h45, 64'hAB, 64'd0, 1);
        do_op(0, 1, 0, 0, 64'h1007, 64'h0123_4567_89AB_CDEF, 64'd0, 2);

        ex_valid = 1'b1; MemRead_ex = 1'b1; ByteSel_ex = 1'b0; alu_result_ex = 64'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_before", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_req_dropped", {63'd0, mem_req}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0; MemRead_ex = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        @(negedge clk);
        chk("late_ack_req", {63'd0, mem_req}, 64'd0);
        chk("late_ack_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_idle", {63'd0, mem_req}, 64'd0);
        @(posedge clk); #1;
        do_op(0, 0, 0, 1, 64'hCAFE, 64'd0, 64'd0, 1);

`ifdef MEM_TIMEOUT_EN
        ex_valid = 1'b1; MemRead_ex = 1'b1; MemWrite_ex = 1'b0; ByteSel_ex = 1'b0;
        alu_result_ex = 64'h200; RegWrite_ex = 1'b1; mem_ack = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_req", {63'd0, mem_req}, 64'd1);
            chk("to_nofault", {63'd0, mem_fault}, 64'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_fault", {63'd0, mem_fault}, 64'd1);
        chk("to_rw", {63'd0, RegWrite_reg_mem}, 64'd0);
        chk("to_data", data_to_reg_mem, 64'd0);
        chk("to_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0; MemRead_ex = 1'b0;
        @(negedge clk);
        chk("to_fault_pulse", {63'd0, mem_fault}, 64'd0);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [63:0] a, wd, rdat;
            kind = $urandom_range(0, 4);
            a    = {$urandom, $urandom};
            wd   = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            case (kind)
                0:       do_op(0, 0, 0, 1'($urandom_range(0, 1)), a, wd, rdat, 1);
                1:       do_op(1, 0, 0, 1, a, wd, rdat, $urandom_range(1, 5));
                2:       do_op(1, 0, 1, 1, a, wd, rdat, $urandom_range(1, 5));
                3:       do_op(0, 1, 0, 0, a, wd, rdat, $urandom_range(1, 5));
                default: do_op(0, 1, 1, 0, a, wd, rdat, $urandom_range(1, 5));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
